reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter: NUM_ENTRIES, 32, ROB depth; fixed power of two, index width 5.
REQ-002 Parameter: STORE_OPCODE, 7'b0100011, opcode treated as store at retire.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 flush  in  1  discard all entries.
REQ-006 alloc_valid  in  1  dispatch requests one entry.
REQ-007 alloc_ready  out  1  entry available this cycle.
REQ-008 alloc_old_preg  in  6  previous physical mapping of rd (old_d_reg).
REQ-009 alloc_new_preg  in  6  newly renamed physical rd (curr_d_reg).
REQ-010 alloc_opcode  in  7  instruction opcode (rd_opcode).
REQ-011 alloc_index  out  5  current tail; the index the next accepted allocation receives.
REQ-012 cmpN_valid / cmpN_index / cmpN_value / cmpN_rs2, N=0,1  in  1/5/32/32  writeback from functional units.
REQ-013 retN_valid  out  1  entry N retired last cycle, N=0,1.
REQ-014 retN_preg / retN_old_preg / retN_value  out  6/6/32  curr_d_reg, old_d_reg (to free list), rd_value of retired entry.
REQ-015 ret_store_valid / ret_store_addr / ret_store_data  out  1/32/32  committed store; addr = rd_value, data = rs2_value.

Function
REQ-016 Storage: 32 entries of {in_use, is_complete, old_d_reg, curr_d_reg, rd_opcode, rd_value, rs2_value}; head, tail (5-bit, wrap 31->0), count (6-bit, 0..32).
REQ-017 alloc_ready = (count < 32), from registered count only; no same-cycle credit from retire.
REQ-018 alloc_valid & alloc_ready: entry[tail] written in_use=1, is_complete=0, fields from alloc_*; tail+1 next cycle.
REQ-019 alloc_valid with alloc_ready=0: ignored, no state change.
REQ-020 Completion: cmpN_valid with entry[cmpN_index].in_use=1 and is_complete=0 sets is_complete=1, rd_value=cmpN_value, rs2_value=cmpN_rs2.
REQ-021 Completion to entry with in_use=0 or is_complete=1: ignored.
REQ-022 cmp0 and cmp1 same index same cycle: cmp0 wins, cmp1 dropped.
REQ-023 Retire decision uses registered is_complete; entry completed in cycle t is retire-eligible no earlier than t+1.
REQ-024 Slot 0 retires entry[head] if in_use & is_complete.
REQ-025 Slot 1 retires entry[head+1] only if slot 0 retires, entry[head+1] in_use & is_complete, and not both entries are stores (max one store per cycle).
REQ-026 Retired entries: in_use=0, is_complete=0; head advances by 0/1/2 with wrap; count = count + alloc - retired.
REQ-027 Retire outputs registered: retN_* and ret_store_* valid exactly one cycle after the retire decision; valid signals low otherwise, data don't-care when invalid.
REQ-028 ret_store_valid = 1 if a retired entry has rd_opcode == STORE_OPCODE; addr/data from that entry.
REQ-029 Retire is in order: a slot-1 retire never occurs without slot 0.
REQ-030 Allocate, complete and retire in same cycle on different indices all take effect.
REQ-031 flush: next cycle all in_use/is_complete=0, head=tail=0, count=0, all valid outputs 0; flush overrides alloc, completion and retire that cycle.

Reset
REQ-032 reset overrides flush and all inputs; next cycle: all entries in_use=0, is_complete=0; head=tail=count=0; alloc_ready=1; alloc_index=0; ret0_valid=ret1_valid=ret_store_valid=0; data outputs 0.
REQ-033 reset asserted mid-operation discards all in-flight entries; no retire outputs in the cycle after reset.

Verification
REQ-034 Allocate 3 ops (new_preg 33,34,35), complete index 1 then 0 -> no retire until index 0 complete; then ret0=idx0, ret1=idx1 same cycle, idx2 pending.
REQ-035 Allocate 32 without retire -> alloc_ready=0 at count=32; 33rd alloc_valid ignored; retire one -> alloc_ready=1 next cycle, tail wraps to 0.
REQ-036 Two adjacent complete stores (opcode 0100011, value 0x100, rs2 0xDEAD) -> one store per cycle, ret1_valid=0 first cycle, second store next cycle.
REQ-037 cmp0 and cmp1 both to index 4 (values 0xA, 0xB) -> rd_value=0xA retired.
REQ-038 Complete entry at head in cycle t -> ret0_valid first high at t+2 (decision t+1, registered output t+2).
REQ-039 flush (and separately reset) with 10 in-flight entries -> count=0, alloc_index=0, no retire outputs; following alloc receives index 0.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation at the tail, out-of-order completion
// from two writeback ports, and in-order retirement of up to two entries per
// cycle (at most one store). Retire outputs are registered one cycle after
// the retire decision.
module reorder_buffer #(
  parameter int          NUM_ENTRIES  = 32,
  parameter logic [6:0]  STORE_OPCODE = 7'b0100011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  // dispatch / allocation
  input  logic        alloc_valid,
  output logic        alloc_ready,
  input  logic [5:0]  alloc_old_preg,
  input  logic [5:0]  alloc_new_preg,
  input  logic [6:0]  alloc_opcode,
  output logic [4:0]  alloc_index,
  // writeback port 0
  input  logic        cmp0_valid,
  input  logic [4:0]  cmp0_index,
  input  logic [31:0] cmp0_value,
  input  logic [31:0] cmp0_rs2,
  // writeback port 1
  input  logic        cmp1_valid,
  input  logic [4:0]  cmp1_index,
  input  logic [31:0] cmp1_value,
  input  logic [31:0] cmp1_rs2,
  // retire slot 0
  output logic        ret0_valid,
  output logic [5:0]  ret0_preg,
  output logic [5:0]  ret0_old_preg,
  output logic [31:0] ret0_value,
  // retire slot 1
  output logic        ret1_valid,
  output logic [5:0]  ret1_preg,
  output logic [5:0]  ret1_old_preg,
  output logic [31:0] ret1_value,
  // committed store
  output logic        ret_store_valid,
  output logic [31:0] ret_store_addr,
  output logic [31:0] ret_store_data
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  // per-entry status bits
  logic [NUM_ENTRIES-1:0] r_in_use;
  logic [NUM_ENTRIES-1:0] r_complete;

  // per-entry payload (no reset needed: only read when the entry is valid)
  logic [5:0]  r_old_preg [NUM_ENTRIES];
  logic [5:0]  r_new_preg [NUM_ENTRIES];
  logic [6:0]  r_opcode   [NUM_ENTRIES];
  logic [31:0] r_value    [NUM_ENTRIES];
  logic [31:0] r_rs2      [NUM_ENTRIES];

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // registered retire outputs
  logic        r_ret0_valid, r_ret1_valid, r_store_valid;
  logic [5:0]  r_ret0_preg, r_ret0_old_preg, r_ret1_preg, r_ret1_old_preg;
  logic [31:0] r_ret0_value, r_ret1_value, r_store_addr, r_store_data;

  logic [IDX_W-1:0] w_head1;
  logic             w_ret0, w_ret1, w_store0, w_store1, w_alloc_fire;
  logic [1:0]       w_ret_cnt;
  logic [NUM_ENTRIES-1:0] w_alloc_hit, w_cmp0_sel, w_cmp0_hit, w_cmp1_hit, w_ret_hit;

  // Occupancy is taken from the registered count only, so a retire in the
  // same cycle never frees a slot for the allocation of that cycle.
  assign alloc_ready  = (r_count < CNT_W'(NUM_ENTRIES));
  assign alloc_index  = r_tail;
  assign w_alloc_fire = alloc_valid & alloc_ready;

  // Retire decision works purely on registered state: a completion written
  // this cycle is only seen by the decision of the next cycle.
  assign w_head1  = r_head + IDX_W'(1);
  assign w_store0 = (r_opcode[r_head]  == STORE_OPCODE);
  assign w_store1 = (r_opcode[w_head1] == STORE_OPCODE);
  assign w_ret0   = r_in_use[r_head] & r_complete[r_head];
  assign w_ret1   = w_ret0 & r_in_use[w_head1] & r_complete[w_head1]
                    & ~(w_store0 & w_store1);
  assign w_ret_cnt = {1'b0, w_ret0} + {1'b0, w_ret1};

  // Per-entry decode of allocate, completion and retire events. Completion
  // only lands on an in-flight, not-yet-complete entry; port 0 has priority
  // when both ports name the same entry.
  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign w_alloc_hit[gi] = w_alloc_fire & (r_tail == IDX_W'(gi));
      assign w_cmp0_sel[gi]  = cmp0_valid & (cmp0_index == IDX_W'(gi));
      assign w_cmp0_hit[gi]  = w_cmp0_sel[gi] & r_in_use[gi] & ~r_complete[gi];
      assign w_cmp1_hit[gi]  = cmp1_valid & (cmp1_index == IDX_W'(gi)) & ~w_cmp0_sel[gi]
                               & r_in_use[gi] & ~r_complete[gi];
      assign w_ret_hit[gi]   = (w_ret0 & (r_head == IDX_W'(gi)))
                             | (w_ret1 & (w_head1 == IDX_W'(gi)));
    end
  endgenerate

  // Status bits, pointers, count and registered retire outputs.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_in_use        <= '0;
      r_complete      <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_ret0_valid    <= 1'b0;
      r_ret1_valid    <= 1'b0;
      r_store_valid   <= 1'b0;
      r_ret0_preg     <= '0;
      r_ret0_old_preg <= '0;
      r_ret0_value    <= '0;
      r_ret1_preg     <= '0;
      r_ret1_old_preg <= '0;
      r_ret1_value    <= '0;
      r_store_addr    <= '0;
      r_store_data    <= '0;
    end else begin
      r_in_use   <= (r_in_use | w_alloc_hit) & ~w_ret_hit;
      r_complete <= (r_complete | w_cmp0_hit | w_cmp1_hit) & ~w_ret_hit & ~w_alloc_hit;
      r_head     <= r_head + IDX_W'(w_ret_cnt);
      r_tail     <= r_tail + IDX_W'(w_alloc_fire);
      r_count    <= r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_ret_cnt);

      r_ret0_valid    <= w_ret0;
      r_ret0_preg     <= r_new_preg[r_head];
      r_ret0_old_preg <= r_old_preg[r_head];
      r_ret0_value    <= r_value[r_head];
      r_ret1_valid    <= w_ret1;
      r_ret1_preg     <= r_new_preg[w_head1];
      r_ret1_old_preg <= r_old_preg[w_head1];
      r_ret1_value    <= r_value[w_head1];

      // At most one store retires; it is the older entry when slot 0 is a store.
      r_store_valid <= (w_ret0 & w_store0) | (w_ret1 & w_store1);
      if (w_store0) begin
        r_store_addr <= r_value[r_head];
        r_store_data <= r_rs2[r_head];
      end else begin
        r_store_addr <= r_value[w_head1];
        r_store_data <= r_rs2[w_head1];
      end
    end
  end

  // Entry payload: allocation fields at dispatch, results at writeback.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_alloc_hit[i]) begin
        r_old_preg[i] <= alloc_old_preg;
        r_new_preg[i] <= alloc_new_preg;
        r_opcode[i]   <= alloc_opcode;
      end
      if (w_cmp0_hit[i]) begin
        r_value[i] <= cmp0_value;
        r_rs2[i]   <= cmp0_rs2;
      end else if (w_cmp1_hit[i]) begin
        r_value[i] <= cmp1_value;
        r_rs2[i]   <= cmp1_rs2;
      end
    end
  end

  assign ret0_valid      = r_ret0_valid;
  assign ret0_preg       = r_ret0_preg;
  assign ret0_old_preg   = r_ret0_old_preg;
  assign ret0_value      = r_ret0_value;
  assign ret1_valid      = r_ret1_valid;
  assign ret1_preg       = r_ret1_preg;
  assign ret1_old_preg   = r_ret1_old_preg;
  assign ret1_value      = r_ret1_value;
  assign ret_store_valid = r_store_valid;
  assign ret_store_addr  = r_store_addr;
  assign ret_store_data  = r_store_data;

endmodule
